// File: rtl/mips32_pkg.sv
// Shared MIPS32 definitions: opcode constants, fetch queue entry type,
// default fetch queue depth and the prefetch state encoding.
package mips32_pkg;

  localparam int FETCHQ_DEPTH = 4;

  localparam logic [5:0] OP_ADD   = 6'b000000;
  localparam logic [5:0] OP_SUB   = 6'b000001;
  localparam logic [5:0] OP_AND   = 6'b000010;
  localparam logic [5:0] OP_OR    = 6'b000011;
  localparam logic [5:0] OP_SLT   = 6'b000100;
  localparam logic [5:0] OP_MUL   = 6'b000101;
  localparam logic [5:0] OP_LW    = 6'b001000;
  localparam logic [5:0] OP_SW    = 6'b001001;
  localparam logic [5:0] OP_ADDI  = 6'b001010;
  localparam logic [5:0] OP_SUBI  = 6'b001011;
  localparam logic [5:0] OP_SLTI  = 6'b001100;
  localparam logic [5:0] OP_BNEQZ = 6'b001101;
  localparam logic [5:0] OP_BEQZ  = 6'b001110;
  localparam logic [5:0] OP_HLT   = 6'b111111;

  typedef struct packed {
    logic [31:0] ir;
    logic [31:0] npc;
  } fetch_entry_t;

  typedef enum logic {
    ST_RUN  = 1'b0,
    ST_STOP = 1'b1
  } fq_state_t;

  function automatic logic is_hlt(input logic [31:0] word);
    return word[31:26] == OP_HLT;
  endfunction

endpackage

// File: rtl/fetchq_fifo.sv
// Synchronous FIFO with push/pop/flush and an occupancy count.
// Element type is a parameter so the same block carries fetch entries or
// bare fetch addresses. Push and pop together are legal even when full.
module fetchq_fifo
  import mips32_pkg::*;
#(
  parameter int  DEPTH = FETCHQ_DEPTH,
  parameter type T     = fetch_entry_t
) (
  input  logic                       i_clk,
  input  logic                       i_rst,
  input  logic                       i_push,
  input  T                           i_data,
  input  logic                       i_pop,
  input  logic                       i_flush,
  output T                           o_head,
  output logic [$clog2(DEPTH+1)-1:0] o_count
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH+1);

  logic [PW-1:0] r_wr_ptr;
  logic [PW-1:0] r_rd_ptr;
  logic [CW-1:0] r_count;
  T              r_mem [DEPTH];

  // pointers and occupancy; flush empties the queue in one cycle
  always_ff @(posedge i_clk) begin
    if (i_rst || i_flush) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (i_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (i_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
      if (i_push && !i_pop)      r_count <= r_count + 1'b1;
      else if (i_pop && !i_push) r_count <= r_count - 1'b1;
    end
  end

  // storage write; contents need no reset since count gates every read
  always_ff @(posedge i_clk) begin
    if (i_push && !i_flush) r_mem[r_wr_ptr] <= i_data;
  end

  assign o_head  = r_mem[r_rd_ptr];
  assign o_count = r_count;

endmodule

// File: rtl/mips32_fetch_queue.sv
// MIPS32 instruction prefetch queue feeding the IF/ID latch.
// Optional macro FETCHQ_BYPASS_EN: when defined, a response arriving at an
// empty queue is presented on the output in the same cycle.
//
// state   | meaning
// --------+-------------------------------------------------------------
// ST_RUN  | issuing fetches while buffered + outstanding < DEPTH
// ST_STOP | HLT fetched; no new requests, queue drains, wait for redirect
module mips32_fetch_queue
  import mips32_pkg::*;
#(
  parameter int          DEPTH    = FETCHQ_DEPTH,
  parameter int          AW       = 10,
  parameter logic [31:0] RESET_PC = 32'd0
) (
  input  logic          clk1,
  input  logic          rst,
  output logic          imem_req_valid,
  input  logic          imem_req_ready,
  output logic [AW-1:0] imem_req_addr,
  input  logic          imem_rsp_valid,
  input  logic [31:0]   imem_rsp_data,
  input  logic          redirect_valid,
  input  logic [31:0]   redirect_pc,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [31:0]   out_ir,
  output logic [31:0]   out_npc
);

  localparam int CW = $clog2(DEPTH+1);

  fq_state_t    r_state;
  fq_state_t    w_state_nxt;
  logic         r_live;
  logic [31:0]  r_pc;
  logic [CW-1:0] r_outstanding;
  logic [CW-1:0] r_discard;
  fetch_entry_t r_hold;

  logic [CW-1:0] w_count;
  logic [CW-1:0] w_trk_count;
  logic [CW:0]   w_credit;
  logic [CW-1:0] w_outstanding_nxt;
  logic [31:0]   w_trk_npc;
  fetch_entry_t  w_head;
  fetch_entry_t  w_rsp_entry;
  fetch_entry_t  w_out_entry;
  logic          w_req_fire;
  logic          w_rsp_in;
  logic          w_rsp_keep;
  logic          w_hlt;
  logic          w_push;
  logic          w_pop;

  assign w_credit       = {1'b0, w_count} + {1'b0, r_outstanding};
  assign imem_req_valid = r_live && (r_state == ST_RUN) && (w_credit < (CW+1)'(DEPTH));
  assign imem_req_addr  = r_pc[AW-1:0];
  assign w_req_fire     = imem_req_valid && imem_req_ready;

  // a response with nothing tracked (stale after reset) is ignored
  assign w_rsp_in    = imem_rsp_valid && (w_trk_count != '0);
  assign w_rsp_keep  = w_rsp_in && (r_discard == '0) && !redirect_valid;
  assign w_hlt       = w_rsp_keep && is_hlt(imem_rsp_data);
  assign w_rsp_entry = '{ir: imem_rsp_data, npc: w_trk_npc};

`ifdef FETCHQ_BYPASS_EN
  logic w_byp;
  assign w_byp       = w_rsp_keep && (w_count == '0);
  assign w_out_entry = (w_count != '0) ? w_head : (w_byp ? w_rsp_entry : r_hold);
  assign out_valid   = ((w_count != '0) || w_byp) && !redirect_valid;
  assign w_push      = w_rsp_keep && !(w_byp && out_ready);
`else
  assign w_out_entry = (w_count != '0) ? w_head : r_hold;
  assign out_valid   = (w_count != '0) && !redirect_valid;
  assign w_push      = w_rsp_keep;
`endif

  assign w_pop   = out_valid && out_ready && (w_count != '0);
  assign out_ir  = w_out_entry.ir;
  assign out_npc = w_out_entry.npc;

  // outstanding count after this cycle's request and response
  always_comb begin
    w_outstanding_nxt = r_outstanding;
    if (w_req_fire && !w_rsp_in)      w_outstanding_nxt = r_outstanding + 1'b1;
    else if (w_rsp_in && !w_req_fire) w_outstanding_nxt = r_outstanding - 1'b1;
  end

  // next state: redirect always restarts, HLT stops prefetching
  always_comb begin
    w_state_nxt = r_state;
    if (redirect_valid) w_state_nxt = ST_RUN;
    else if (w_hlt)     w_state_nxt = ST_STOP;
  end

  // state register
  always_ff @(posedge clk1) begin
    if (rst) r_state <= ST_RUN;
    else     r_state <= w_state_nxt;
  end

  // holds requests off during the reset cycle itself
  always_ff @(posedge clk1) begin
    if (rst) r_live <= 1'b0;
    else     r_live <= 1'b1;
  end

  // fetch PC, outstanding credits and pending discards
  always_ff @(posedge clk1) begin
    if (rst) begin
      r_pc          <= RESET_PC;
      r_outstanding <= '0;
      r_discard     <= '0;
    end else begin
      if (redirect_valid)  r_pc <= redirect_pc;
      else if (w_req_fire) r_pc <= r_pc + 32'd1;
      r_outstanding <= w_outstanding_nxt;
      if (redirect_valid || w_hlt)      r_discard <= w_outstanding_nxt;
      else if (w_rsp_in && r_discard != '0) r_discard <= r_discard - 1'b1;
    end
  end

  // last consumed entry, shown while the queue is empty
  always_ff @(posedge clk1) begin
    if (rst)                         r_hold <= '0;
    else if (out_valid && out_ready) r_hold <= w_out_entry;
  end

  fetchq_fifo #(.DEPTH(DEPTH), .T(logic [31:0])) u_npc_trk (
    .i_clk   (clk1),
    .i_rst   (rst),
    .i_push  (w_req_fire),
    .i_data  (r_pc + 32'd1),
    .i_pop   (w_rsp_in),
    .i_flush (1'b0),
    .o_head  (w_trk_npc),
    .o_count (w_trk_count)
  );

  fetchq_fifo #(.DEPTH(DEPTH), .T(fetch_entry_t)) u_out_q (
    .i_clk   (clk1),
    .i_rst   (rst),
    .i_push  (w_push),
    .i_data  (w_rsp_entry),
    .i_pop   (w_pop),
    .i_flush (redirect_valid),
    .o_head  (w_head),
    .o_count (w_count)
  );

endmodule

// File: tb/tb_mips32_fetch_queue.sv
// Scoreboard bench for mips32_fetch_queue: a memory model answers fetches,
// stimulus pushes expected {IR, NPC} entries, a monitor pops and compares.
module tb_mips32_fetch_queue;
  import mips32_pkg::*;

`ifdef FETCHQ_BYPASS_EN
  localparam int EXP_LAT = 0;
`else
  localparam int EXP_LAT = 1;
`endif

  logic        clk1 = 1'b0;
  logic        rst;
  logic        imem_req_valid;
  logic        imem_req_ready;
  logic [9:0]  imem_req_addr;
  logic        imem_rsp_valid;
  logic [31:0] imem_rsp_data;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_ir;
  logic [31:0] out_npc;

  mips32_fetch_queue dut (
    .clk1           (clk1),
    .rst            (rst),
    .imem_req_valid (imem_req_valid),
    .imem_req_ready (imem_req_ready),
    .imem_req_addr  (imem_req_addr),
    .imem_rsp_valid (imem_rsp_valid),
    .imem_rsp_data  (imem_rsp_data),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .out_valid      (out_valid),
    .out_ready      (out_ready),
    .out_ir         (out_ir),
    .out_npc        (out_npc)
  );

  always #5 clk1 = ~clk1;

  int vectors = 0;
  int miscompares = 0;
  int cyc = 0;
  int n_out = 0;
  int lat = 1;
  logic mem_ready = 1'b1;

  typedef struct { logic [9:0] addr; int due; } pend_t;
  pend_t        pend[$];
  fetch_entry_t exp_q[$];
  logic [9:0]   acc_log[$];
  int           rsp_cyc[$];
  int           out_cyc[$];
  logic [31:0]  mem [1024];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    vectors++;
    if (act !== req) begin
      miscompares++;
      $display("FAIL %s: got %h, expected %h", name, act, req);
    end
  endtask

  function automatic logic [31:0] acc_at(input int i);
    if (i < acc_log.size()) return {22'd0, acc_log[i]};
    return 32'hDEAD_BEEF;
  endfunction

  task automatic expect_run(input logic [31:0] start, input int n);
    logic [31:0] p;
    p = start;
    for (int i = 0; i < n; i++) begin
      exp_q.push_back('{ir: mem[p[9:0]], npc: p + 32'd1});
      p = p + 32'd1;
    end
  endtask

  task automatic wait_drain(input string name, input int budget);
    int k;
    k = 0;
    while (exp_q.size() != 0 && k < budget) begin
      @(negedge clk1);
      k++;
    end
    chk(name, exp_q.size(), 0);
  endtask

  task automatic wait_outputs(input string name, input int n, input int budget);
    int k;
    k = 0;
    while (n_out < n && k < budget) begin
      @(negedge clk1);
      k++;
    end
    chk(name, n_out, n);
  endtask

  task automatic check_no_requests(input string name, input int cycles);
    int hi;
    hi = 0;
    repeat (cycles) begin
      @(negedge clk1);
      #4;
      if (imem_req_valid) hi++;
    end
    chk(name, hi, 0);
  endtask

  always @(posedge clk1) cyc <= cyc + 1;

  // instruction memory: in-order responses after lat cycles
  always @(negedge clk1) begin
    pend_t p;
    imem_req_ready = mem_ready;
    if (rst) begin
      pend.delete();
      imem_rsp_valid = 1'b0;
    end else begin
      if (pend.size() > 0 && pend[0].due <= cyc) begin
        p = pend.pop_front();
        imem_rsp_valid = 1'b1;
        imem_rsp_data  = mem[p.addr];
        rsp_cyc.push_back(cyc);
      end else begin
        imem_rsp_valid = 1'b0;
      end
      if (imem_req_valid && imem_req_ready) begin
        pend.push_back('{addr: imem_req_addr, due: cyc + lat});
        acc_log.push_back(imem_req_addr);
      end
    end
  end

  // monitor: every consumed output must match the scoreboard head
  always @(negedge clk1) begin
    fetch_entry_t e;
    #4;
    if (!rst && out_valid && out_ready) begin
      if (exp_q.size() == 0) begin
        vectors++;
        miscompares++;
        $display("FAIL unexpected_out: got ir=%h npc=%h, expected no output", out_ir, out_npc);
      end else begin
        e = exp_q.pop_front();
        chk("out_ir", out_ir, e.ir);
        chk("out_npc", out_npc, e.npc);
      end
      out_cyc.push_back(cyc);
      n_out++;
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: bench did not reach its end");
    $fatal(1, "watchdog");
  end

  initial begin
    int k;
    for (int i = 0; i < 1024; i++) mem[i] = {6'b000000, 5'd1, 5'd2, 5'd3, 1'b0, i[9:0]};
    mem[5] = 32'hFC00_0000;
    rst = 1'b1;
    redirect_valid = 1'b0;
    redirect_pc = '0;
    out_ready = 1'b1;
    imem_req_ready = 1'b1;
    imem_rsp_valid = 1'b0;
    imem_rsp_data = '0;

    // reset values
    repeat (3) @(negedge clk1);
    #4;
    chk("rst_req_valid", imem_req_valid, 0);
    chk("rst_req_addr", imem_req_addr, 0);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_ir", out_ir, 0);
    chk("rst_out_npc", out_npc, 0);

    // straight-line fetch 0..5, HLT at 5
    @(negedge clk1);
    rst = 1'b0;
    acc_log.delete(); rsp_cyc.delete(); out_cyc.delete(); n_out = 0;
    expect_run(32'd0, 6);
    #4;
    chk("req_valid_deassert_cycle", imem_req_valid, 0);
    @(negedge clk1);
    #4;
    chk("first_req_valid", imem_req_valid, 1);
    chk("first_req_addr", imem_req_addr, 0);
    wait_drain("drain_seq", 60);
    for (int i = 0; i < 4; i++) chk("seq_req_addr", acc_at(i), i);
    if (out_cyc.size() >= 6 && rsp_cyc.size() >= 1) begin
      chk("throughput", out_cyc[5] - out_cyc[0], 5);
      chk("latency", out_cyc[0] - rsp_cyc[0], EXP_LAT);
    end else begin
      chk("seq_output_count", out_cyc.size(), 6);
    end
    check_no_requests("halt_no_req", 10);

    // restart at 0x10, backpressure with 2-cycle memory
    @(negedge clk1);
    lat = 2;
    out_ready = 1'b0;
    redirect_valid = 1'b1;
    redirect_pc = 32'h10;
    acc_log.delete(); n_out = 0;
    expect_run(32'h10, 8);
    #4;
    chk("redir_stop_out_valid", out_valid, 0);
    @(negedge clk1);
    redirect_valid = 1'b0;
    repeat (10) @(negedge clk1);
    chk("credit_cap_reqs", acc_log.size(), 4);
    chk("restart_addr", acc_at(0), 32'h10);
    out_ready = 1'b1;
    wait_outputs("resume_outputs", 6, 60);
    out_ready = 1'b0;
    repeat (3) @(negedge clk1);

    // redirect with entries buffered: flushed and in-flight data dropped
    redirect_valid = 1'b1;
    redirect_pc = 32'h20;
    exp_q.delete();
    expect_run(32'h20, 16);
    #4;
    chk("redir_buf_out_valid", out_valid, 0);
    @(negedge clk1);
    redirect_valid = 1'b0;
    out_ready = 1'b1;
    n_out = 0;
    wait_outputs("target_outputs", 4, 40);

    // redirect in a cycle carrying a response; target exercises PC wrap
    k = 0;
    do begin
      @(negedge clk1);
      #1;
      k++;
    end while (!imem_rsp_valid && k < 20);
    chk("rsp_for_redirect", imem_rsp_valid, 1);
    redirect_valid = 1'b1;
    redirect_pc = 32'h3FE;
    exp_q.delete();
    acc_log.delete();
    expect_run(32'h3FE, 8);
    #3;
    chk("redir_rsp_out_valid", out_valid, 0);
    @(negedge clk1);
    redirect_valid = 1'b0;
    wait_drain("drain_wrap", 80);
    chk("wrap_addr0", acc_at(0), 32'h3FE);
    chk("wrap_addr1", acc_at(1), 32'h3FF);
    chk("wrap_addr2", acc_at(2), 32'h000);
    check_no_requests("halt2_no_req", 8);
    chk("final_queue_empty", exp_q.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
